// File: rtl/scroll_sequencer.sv
// scroll_sequencer: holds a short text message and shows a sliding
// WINDOW-character view of it. It arms the external scrolling_timer,
// waits for that timer to expire, and then advances the view by one
// character, wrapping at the end of the message.
//
// Timer handshake: cnt_start is a one-cycle request. It is raised only in
// ARM, and cnt_value carries the delay for that request. cnt_done is a
// one-cycle response. It is honoured only in WAIT and is ignored in every
// other state, so a stale expiry that arrives after a pause or restart can
// never cause a step. There is no back-pressure in either direction.
module scroll_sequencer #(
  parameter int                CHAR_W  = 8,
  parameter int                MAX_LEN = 32,
  parameter int                WINDOW  = 4,
  parameter logic [CHAR_W-1:0] BLANK   = 8'h20,
  parameter int                ADDR_W  = $clog2(MAX_LEN)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic [ADDR_W-1:0]        wr_addr,
  input  logic [CHAR_W-1:0]        wr_data,
  input  logic [ADDR_W:0]          msg_len,
  input  logic [31:0]              scroll_delay,
  input  logic                     enable,
  input  logic                     restart,
  output logic                     cnt_start,
  output logic [31:0]              cnt_value,
  input  logic                     cnt_done,
  output logic [ADDR_W-1:0]        offset,
  output logic [WINDOW*CHAR_W-1:0] window_data,
  output logic                     step,
  output logic                     busy
);

  localparam logic [ADDR_W:0] WIN_LEN = (ADDR_W+1)'(WINDOW);

  typedef enum logic [1:0] {S_IDLE, S_ARM, S_WAIT, S_STEP} state_t;

  state_t                   state_q, state_d;
  logic [ADDR_W-1:0]        offset_q, offset_d;
  logic [ADDR_W:0]          len_q, len_d;
  logic [31:0]              cnt_value_q, cnt_value_d;
  logic [WINDOW*CHAR_W-1:0] window_q, window_d;
  logic [CHAR_W-1:0]        buf_q [MAX_LEN];
  logic [CHAR_W-1:0]        buf_d [MAX_LEN];
  logic [ADDR_W:0]          off_inc;

  assign busy        = (state_q != S_IDLE);
  assign cnt_start   = (state_q == S_ARM) && !restart;
  assign step        = (state_q == S_STEP) && !restart;
  assign cnt_value   = cnt_value_q;
  assign offset      = offset_q;
  assign window_data = window_q;
  assign off_inc     = {1'b0, offset_q} + (ADDR_W+1)'(1);

  // Next-state logic: restart overrides the state machine; the message length is captured when leaving IDLE.
  always_comb begin
    state_d     = state_q;
    offset_d    = offset_q;
    len_d       = len_q;
    cnt_value_d = cnt_value_q;
    if (restart) begin
      state_d  = S_IDLE;
      offset_d = '0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (enable && (msg_len > WIN_LEN)) begin
            state_d     = S_ARM;
            len_d       = msg_len;
            cnt_value_d = scroll_delay;
          end
        end
        S_ARM: begin
          state_d = S_WAIT;
        end
        S_WAIT: begin
          // A pause beats a simultaneous expiry.
          if (!enable) begin
            state_d = S_IDLE;
          end else if (cnt_done) begin
            state_d = S_STEP;
          end
        end
        S_STEP: begin
          offset_d = (off_inc == len_q) ? '0 : off_inc[ADDR_W-1:0];
          if (enable) begin
            state_d     = S_ARM;
            cnt_value_d = scroll_delay;
          end else begin
            state_d = S_IDLE;
          end
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

  // Window: a circular view starting at offset; a message shorter than the window is shown left-aligned.
  always_comb begin
    logic [ADDR_W:0]   win_len;
    logic [ADDR_W:0]   idx;
    logic [ADDR_W:0]   slot_i;
    logic [CHAR_W-1:0] slot;
    win_len  = busy ? len_q : msg_len;
    idx      = '0;
    slot_i   = '0;
    slot     = BLANK;
    window_d = {WINDOW{BLANK}};
    for (int i = 0; i < WINDOW; i++) begin
      slot_i = (ADDR_W+1)'(i);
      idx    = {1'b0, offset_q} + slot_i;
      if (idx >= win_len) begin
        idx = idx - win_len;
      end
      // A zero-length message falls into the short branch and shows all BLANK.
      if (win_len < WIN_LEN) begin
        slot = (slot_i < win_len) ? buf_q[slot_i[ADDR_W-1:0]] : BLANK;
      end else begin
        slot = buf_q[idx[ADDR_W-1:0]];
      end
      window_d[i*CHAR_W +: CHAR_W] = slot;
    end
  end

  // Buffer write port: one character per cycle.
  always_comb begin
    buf_d = buf_q;
    if (wr_en) begin
      buf_d[wr_addr] = wr_data;
    end
  end

  // Control and window registers, with a synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      offset_q    <= '0;
      len_q       <= '0;
      cnt_value_q <= '0;
      window_q    <= {WINDOW{BLANK}};
    end else begin
      state_q     <= state_d;
      offset_q    <= offset_d;
      len_q       <= len_d;
      cnt_value_q <= cnt_value_d;
      window_q    <= window_d;
    end
  end

  // Message storage is not reset, so text survives a reset.
  always_ff @(posedge clk) begin
    buf_q <= buf_d;
  end

endmodule
